// File: rtl/half_subtractor_pkg.sv
// half_subtractor_pkg: shared widths and truth-table constants indexed by {a,b}
package half_subtractor_pkg;
  localparam int STATS_W = 16;
  localparam logic [3:0] TT_SUB = 4'b0110;
  localparam logic [3:0] TT_BOR = 4'b0010;
endpackage

// File: rtl/half_subtractor_cell.sv
// half_subtractor_cell: combinational 1-bit difference and borrow of a - b
module half_subtractor_cell (
  input  logic a,
  input  logic b,
  output logic sub,
  output logic bor
);
  assign sub = a ^ b;
  assign bor = ~a & b;
endmodule

// File: rtl/half_subtractor.sv
// half_subtractor: registered lane-parallel half subtractor, borrow counter under HALF_SUBTRACTOR_STATS_EN
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sub,
  output logic [WIDTH-1:0] bor,
  output logic             out_valid
`ifdef HALF_SUBTRACTOR_STATS_EN
  ,
  output logic [STATS_W-1:0] borrow_cnt
`endif
);
  logic [WIDTH-1:0] sub_d, bor_d, sub_q, bor_q;
  logic             valid_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .sub(sub_d[i]),
      .bor(bor_d[i])
    );
  end
  // Results load only on valid so idle-cycle inputs never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      bor_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sub_q <= sub_d;
        bor_q <= bor_d;
      end
    end
  end
  assign sub       = sub_q;
  assign bor       = bor_q;
  assign out_valid = valid_q;
`ifdef HALF_SUBTRACTOR_STATS_EN
  logic [STATS_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = (in_valid && |bor_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign borrow_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_half_subtractor.sv
// tb_half_subtractor: randomized self-checking bench for half_subtractor against an arithmetic model
module tb_half_subtractor;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] sub, bor;
  logic out_valid;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_sub = '0, exp_bor = '0;
  logic exp_valid = 1'b0;
  int exp_cnt = 0;
`ifdef HALF_SUBTRACTOR_STATS_EN
  logic [15:0] borrow_cnt;
`endif
  half_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .bor      (bor),
    .out_valid(out_valid)
`ifdef HALF_SUBTRACTOR_STATS_EN
    ,
    .borrow_cnt(borrow_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic void ref_model(input logic [W-1:0] ai, bi, output logic [W-1:0] s, bo);
    for (int i = 0; i < W; i++) begin
      int d;
      d = int'(ai[i]) - int'(bi[i]);
      s[i] = (d != 0);
      bo[i] = (d < 0);
    end
  endfunction
  task automatic check_all(input string tag);
    checks++;
    if (sub !== exp_sub) begin
      errors++;
      $display("FAIL %s sub: got %b expected %b", tag, sub, exp_sub);
    end
    checks++;
    if (bor !== exp_bor) begin
      errors++;
      $display("FAIL %s bor: got %b expected %b", tag, bor, exp_bor);
    end
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_valid);
    end
`ifdef HALF_SUBTRACTOR_STATS_EN
    checks++;
    if (borrow_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s borrow_cnt: got %0d expected %0d", tag, borrow_cnt, exp_cnt);
    end
`endif
  endtask
  task automatic drive(input logic v, input logic [W-1:0] ai, bi, input string tag);
    logic [W-1:0] s, bo;
    @(negedge clk);
    in_valid = v;
    a = ai;
    b = bi;
    @(posedge clk);
    ref_model(ai, bi, s, bo);
    if (v) begin
      exp_sub = s;
      exp_bor = bo;
      if (bo != '0 && exp_cnt < 65535) exp_cnt++;
    end
    exp_valid = v;
    #1 check_all(tag);
  endtask
  task automatic clear_model();
    exp_sub = '0;
    exp_bor = '0;
    exp_valid = 1'b0;
    exp_cnt = 0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = '1;
    b = '1;
    repeat (3) begin
      @(posedge clk);
      #1 check_all("reset_held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0000, 4'b1111, "pre_async");
    @(posedge clk);
    #3 rst_n = 1'b0;
    clear_model();
    #1 check_all("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_sequence();
    logic [W-1:0] av [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
    logic [W-1:0] bv [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) drive(1'b1, av[i], bv[i], "truth_table");
  endtask
  task automatic test_hold();
    drive(1'b1, 4'b0000, 4'b0001, "hold_load");
    drive(1'b0, 4'b0001, 4'b0000, "hold_idle");
    drive(1'b0, 4'bxxxx, 4'bxxxx, "hold_x");
  endtask
  task automatic test_lanes();
    drive(1'b1, 4'b0101, 4'b0011, "lanes");
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), "random");
  endtask
  task automatic test_midreset();
    drive(1'b1, 4'b0000, 4'b1111, "mid_pre");
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'b1111;
    b = 4'b0000;
    #1 rst_n = 1'b0;
    clear_model();
    #1 check_all("mid_async");
    @(posedge clk);
    #1 check_all("mid_discard");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, "mid_idle");
    drive(1'b1, 4'b1111, 4'b0000, "mid_first");
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, W'(i), W'(15 - i), "back_to_back");
  endtask
`ifdef HALF_SUBTRACTOR_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 4'b0001, "stats_borrow");
    drive(1'b1, 4'b0001, 4'b0001, "stats_none");
    drive(1'b1, 4'b0001, 4'b0000, "stats_none");
    checks++;
    if (exp_cnt != 3) begin
      errors++;
      $display("FAIL stats_three model: got %0d expected 3", exp_cnt);
    end
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'b0000;
    b = 4'b0001;
    repeat (65531) @(posedge clk);
    exp_cnt = 16'hFFFE;
    #1 check_all("stats_fffe");
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 4'b0001, "stats_sat");
    checks++;
    if (borrow_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h expected ffff", borrow_cnt);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_lanes();
    test_back_to_back();
    test_random();
    test_midreset();
`ifdef HALF_SUBTRACTOR_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/half_subtractor.md
Name: half_subtractor

Overview:
- Registered, lane-parallel half subtractor: per bit computes difference and borrow of a − b.
- Results are captured one clock after a valid input.
- Used as a leaf arithmetic block feeding wider subtract/compare datapaths; no backpressure.

Parameters:
- WIDTH, 1, number of independent 1-bit subtract lanes (≥1).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a/b valid this cycle.
- a, input, WIDTH, minuend bits.
- b, input, WIDTH, subtrahend bits.
- sub, output, WIDTH, registered difference per lane.
- bor, output, WIDTH, registered borrow-out per lane.
- out_valid, output, 1, sub/bor updated with a new result this cycle.

Behaviour:
- Per lane i, combinationally:
  - sub_i = a_i XOR b_i
  - bor_i = (NOT a_i) AND b_i
- Truth table (a,b → sub,bor): 00→0,0; 01→1,1; 10→1,0; 11→0,0.
- Latency is exactly 1 cycle.
  - On a rising clk with in_valid=1: sub/bor load the computed values; out_valid←1.
  - in_valid=0: sub/bor hold their last values; out_valid←0.
- Back-to-back valid inputs are accepted every cycle; throughput is 1 result per clk.
- Reset:
  - rst_n=0 asynchronously forces sub=0, bor=0, out_valid=0 immediately, independent of clk.
  - Reset asserted mid-stream discards any in-flight result.
  - First result after deassertion appears 1 cycle after the first in_valid=1 sampled with rst_n=1.
- Lanes are fully independent; no borrow ripples between lanes.
- X on a/b while in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro: HALF_SUBTRACTOR_STATS_EN.
- Defined:
  - Adds output port borrow_cnt [15:0].
  - Increments by 1 on each accepted result (in_valid=1 at the clk edge) whose computed bor has any bit set.
  - Saturates at 16'hFFFF; never wraps.
  - Reset to 0 by rst_n.
  - Updates on the same edge as out_valid.
- Not defined: borrow_cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package half_subtractor_pkg:
  - localparam STATS_W = 16.
  - Truth-table constants, for bench reuse.
- Sub-module half_subtractor_cell:
  - Purely combinational 1-bit cell, ports a, b, sub, bor.
  - Instantiated WIDTH times via generate.
  - Top level owns the registers, valid pipeline and stats counter.

Test Plan:
- Reset check: rst_n=0 with in_valid=1, a=1, b=1 → sub=0, bor=0, out_valid=0 throughout; outputs clear asynchronously, with no clk edge required.
- WIDTH=1 sequence, one per cycle with in_valid=1: (0,0), (0,1), (1,1), (1,0) → one cycle later (sub,bor) = (0,0), (1,1), (0,0), (1,0); out_valid=1 each cycle.
- Hold: after a=0, b=1 is accepted, drive in_valid=0 with a=1, b=0 → sub=1, bor=1 hold; out_valid=0.
- WIDTH=4 lane independence: a=4'b0101, b=4'b0011 → sub=4'b0110, bor=4'b0010.
- Mid-stream reset: assert rst_n=0 between two valid inputs → outputs 0 immediately; the next result appears exactly 1 cycle after the first post-reset valid.
- STATS_EN: issue 3 borrowing inputs (a=0, b=1) and 2 non-borrowing inputs → borrow_cnt=3; force the counter to 16'hFFFE, then 3 borrows → borrow_cnt=16'hFFFF.
